// File: rtl/enc_rr_pkg.sv
// enc_rr_sched shared package
// Request/index widths and picker helpers.
package enc_rr_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic req_t onehot(input idx_t idx);
    req_t v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotate left by sh, wrapping modulo N_REQ.
  function automatic req_t rotl(input req_t vec, input idx_t sh);
    req_t v;
    idx_t j;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = idx_t'(i) + sh;
      v[j] = vec[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// rr_prio_enc: round-robin priority encoder
// Lowest set bit of vec at or after ptr, wrapping.
module rr_prio_enc
  import enc_rr_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  req_t rot;
  idx_t lo;

  // Rotate so ptr lands at bit 0, then find lowest set bit.
  always_comb begin
    rot = rotl(vec, idx_t'(0) - ptr);
    lo  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) lo = idx_t'(i);
    end
  end

  assign any = |vec;
  assign idx = lo + ptr;

endmodule

// File: rtl/enc_rr_sched.sv
// enc_rr_sched: pending-set capture and round-robin issue
// One registered index per accepted handshake.
module enc_rr_sched
  import enc_rr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             ovf
);

  req_t pending_q, pending_d;
  idx_t ptr_q, ptr_d;
  logic valid_q, valid_d;
  idx_t idx_q, idx_d;
  logic ovf_q, ovf_d;

  logic load;
  logic pick_any;
  idx_t pick;
  req_t load_mask;

  rr_prio_enc u_pick (
    .vec (pending_q),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick)
  );

  // Output load, pending update and overflow detection.
  always_comb begin
    load      = !valid_q || out_ready;
    valid_d   = valid_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    load_mask = '0;
    if (load) begin
      if (pick_any) begin
        valid_d   = 1'b1;
        idx_d     = pick;
        ptr_d     = pick + idx_t'(1);
        load_mask = onehot(pick);
      end else begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end
    // A re-request on the line being loaded stays pending.
    pending_d = (pending_q & ~load_mask) | req_in;
    ovf_d     = |(req_in & pending_q & ~load_mask);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign ovf       = ovf_q;
  assign busy      = |pending_q || valid_q;

endmodule

// File: tb/tb_enc_rr_sched.sv
// tb_enc_rr_sched: scoreboard bench
// Event-level model feeds per-cycle and per-accept queues.
module tb_enc_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       busy;
  logic       ovf;

  enc_rr_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int idx;
    bit ovf;
    bit busy;
  } exp_t;

  exp_t cycq[$];
  int   accq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  // Model: set of pending lines, rotating start position, one output slot.
  bit mpend[8];
  int mptr;
  bit mv;
  int midx;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mpend[i]) mpend[i] = 1'b0;
    mptr = 0;
    mv   = 1'b0;
    midx = 0;
    cycq.delete();
    accq.delete();
  endtask

  // One clock edge of the model, given the inputs held during the cycle.
  task automatic model_step(input logic [7:0] req, input bit rdy);
    bit   ld, have, drop, bz;
    int   pick;
    exp_t e;
    ld   = !mv || rdy;
    have = 1'b0;
    pick = 0;
    for (int k = 0; k < 8; k++) begin
      int p;
      p = (mptr + k) % 8;
      if (!have && mpend[p]) begin
        have = 1'b1;
        pick = p;
      end
    end
    drop = 1'b0;
    for (int i = 0; i < 8; i++)
      if (req[i] && mpend[i] && !(ld && have && pick == i)) drop = 1'b1;
    if (ld) begin
      if (have) begin
        mv          = 1'b1;
        midx        = pick;
        mptr        = (pick + 1) % 8;
        mpend[pick] = 1'b0;
        accq.push_back(pick);
      end else begin
        mv   = 1'b0;
        midx = 0;
      end
    end
    for (int i = 0; i < 8; i++)
      if (req[i]) mpend[i] = 1'b1;
    bz = mv;
    foreach (mpend[i]) if (mpend[i]) bz = 1'b1;
    e.v    = mv;
    e.idx  = midx;
    e.ovf  = drop;
    e.busy = bz;
    cycq.push_back(e);
  endtask

  // Drive one cycle of inputs, then advance the model past the edge.
  task automatic cyc(input logic [7:0] req, input bit rdy);
    req_in    = req;
    out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(req, rdy);
  endtask

  // Monitor: per-cycle output checks and accepted-index scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (cycq.size() > 0) begin
        exp_t e;
        e = cycq.pop_front();
        chk("out_valid", int'(out_valid), int'(e.v));
        chk("out_idx", int'(out_idx), e.idx);
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("busy", int'(busy), int'(e.busy));
      end
      if (out_valid && out_ready) begin
        n_acc++;
        if (accq.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          chk("accept_idx", int'(out_idx), accq.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    bit hit;
    rst       = 1'b1;
    req_in    = '0;
    out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, then wrap-order pair, then 7/1 pair.
    cyc(8'h04, 1'b1);
    repeat (3) cyc(8'h00, 1'b1);
    cyc(8'h05, 1'b1);
    repeat (4) cyc(8'h00, 1'b1);
    cyc(8'h82, 1'b1);
    repeat (4) cyc(8'h00, 1'b1);

    // Hold under backpressure, then accept.
    cyc(8'h10, 1'b0);
    repeat (6) cyc(8'h00, 1'b0);
    repeat (2) cyc(8'h00, 1'b1);

    // Re-pend while held, then overflow on a second pulse.
    cyc(8'h10, 1'b0);
    repeat (3) cyc(8'h00, 1'b0);
    cyc(8'h10, 1'b0);
    repeat (2) cyc(8'h00, 1'b0);
    cyc(8'h10, 1'b0);
    repeat (2) cyc(8'h00, 1'b0);
    repeat (5) cyc(8'h00, 1'b1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      case ($urandom_range(0, 2))
        0: r = 8'h00;
        1: r = 8'(1 << $urandom_range(0, 7));
        default: r = 8'($urandom) & 8'($urandom);
      endcase
      cyc(r, $urandom_range(0, 3) != 0);
    end
    repeat (20) cyc(8'h00, 1'b1);

    // Async reset in the middle of a burst.
    cyc(8'hFF, 1'b1);
    base = n_acc;
    hit  = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cyc(8'h00, 1'b1);
      if (n_acc >= base + 3) hit = 1'b1;
    end
    chk("burst_accepts_reached", int'(hit), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) cyc(8'h00, 1'b1);
    cyc(8'h40, 1'b1);
    repeat (4) cyc(8'h00, 1'b1);

    @(negedge clk);
    #1;
    chk("accq_drained", accq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
